icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
- REQ-001: Parameter NSETS, default 16, number of direct-mapped one-word lines (power of 2, 2..256).
- REQ-002: Parameter IDX_W, default 4, index width, SHALL equal log2(NSETS).
- REQ-003: CLK  in  1  single clock; all state updates on posedge CLK.
- REQ-004: RST  in  1  reset, asynchronous, active-high.
- REQ-005: imemREN  in  1  datapath instruction read request.
- REQ-006: imemaddr  in  32  datapath fetch address. Bits [1:0] are ignored, index is [IDX_W+1:2], tag is [31:IDX_W+2].
- REQ-007: ihit  out  1  requested word valid this cycle.
- REQ-008: imemload  out  32  instruction word returned to the datapath.
- REQ-009: iREN  out  1  memory-side read request.
- REQ-010: iaddr  out  32  memory-side word address.
- REQ-011: iwait  in  1  memory busy; iload is valid in the cycle iwait=0 while iREN=1.
- REQ-012: iload  in  32  memory-side read data.
- REQ-013: flush  in  1  invalidates all lines.
- REQ-014: hit_count  out  32  hit statistics counter.
- REQ-015: miss_count  out  32  miss statistics counter.

Function
- REQ-016: Per-line storage is valid (1 bit), tag (32-IDX_W-2 bits) and data (32 bits). Control is a two-state FSM: IDLE and FETCH.
- REQ-017: hit = imemREN & state==IDLE & valid[idx] & tag[idx]==imemaddr tag. ihit=hit combinationally, giving zero-cycle hit latency.
- REQ-018: imemload = data[idx] when ihit=1, else 32'h0.
- REQ-019: IDLE -> FETCH when imemREN=1 and hit=0. On that edge, {imemaddr[31:2],2'b00} is latched into miss_addr.
- REQ-020: In FETCH, iREN=1 and iaddr=miss_addr. In IDLE, iREN=0 and iaddr=32'h0.
- REQ-021: In FETCH with iwait=0, the next edge writes the line at miss_addr's index: valid=1, tag from miss_addr, data=iload. State returns to IDLE.
- REQ-022: Miss-to-ihit latency is (memory wait cycles + 1 fill cycle). ihit rises in the first IDLE cycle after the fill if imemaddr is unchanged.
- REQ-023: In FETCH with iwait=1, the FSM holds FETCH and ihit=0.
- REQ-024: imemaddr changes or imemREN drops during FETCH: the fill for miss_addr still completes. The new address is evaluated in IDLE afterwards.
- REQ-025: flush=1 at an edge clears all valid bits and forces the FSM to IDLE. Any in-progress fill is discarded, even when iwait=0 in the same cycle, so flush wins over fill.
- REQ-026: flush does not mask ihit in its own cycle; invalidation takes effect after the edge.
- REQ-027: A line is replaced unconditionally on fill; there is no write path from the datapath.

Reset
- REQ-028: While RST=1, all valid bits are 0, state=IDLE, miss_addr=0, and hit_count and miss_count are 0.
- REQ-029: During reset, outputs are ihit=0, imemload=0, iREN=0 and iaddr=0, asserted asynchronously.
- REQ-030: RST during FETCH abandons the fill; iREN falls without waiting for a clock.
- REQ-031: Tag and data arrays need no reset.

Configuration
- REQ-032: Macro ICACHE_STATS_EN controls the statistics counters.
- REQ-033: With ICACHE_STATS_EN defined, hit_count increments on each edge where ihit=1, and miss_count increments on each IDLE->FETCH transition. Both saturate at 32'hFFFFFFFF, clear only on RST, and are unaffected by flush.
- REQ-034: Without ICACHE_STATS_EN, the hit_count and miss_count ports remain and are tied to 32'h0, and no counter flops are inferred.

Verification
- REQ-035: Cold miss: after reset, imemREN=1 and imemaddr=32'h0000_0040, memory iwait=1 for 3 cycles then iload=32'h2001_0005. Required: iREN=1 and iaddr=32'h0000_0040 for 4 cycles, then ihit=1 and imemload=32'h2001_0005 one cycle later.
- REQ-036: Conflict: fill 32'h0000_0040, then request 32'h0000_0080 (same index 0, different tag). Required: a miss, a refill, then 32'h40 misses again.
- REQ-037: Address change mid-FETCH: miss on 32'h0000_0004, switch imemaddr to 32'h0000_0008 while iwait=1. Required: iaddr stays 32'h4 and the line for 4 fills, then a new miss on 32'h8.
- REQ-038: Flush with fill: flush=1 and iwait=0 in the same FETCH cycle. Required: IDLE next cycle, the same address misses again, and all previously valid lines miss.
- REQ-039: Async reset mid-FETCH: RST raised between clock edges. Required: iREN=0 immediately, and ihit=0 with all lines invalid afterwards.
- REQ-040: Statistics with ICACHE_STATS_EN: 2 misses plus 5 hit cycles gives miss_count=2 and hit_count=5. Without the macro, both counters read 0.

Source files
------------

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache -- direct-mapped, one-word-per-line instruction cache
//
// A hit returns the instruction combinationally in the same cycle. A miss moves
// a two-state controller (IDLE/FETCH) into FETCH. In FETCH the cache holds a
// read request to memory until the memory releases iwait. It then writes the
// returned word into the line and goes back to IDLE. An active flush clears
// every valid bit and abandons any fill that is in progress.
//
// Parameters
//   NSETS       number of lines (power of 2, 2..256)
//   IDX_W       log2(NSETS)
//
// Ports
//   CLK         clock; all state updates on the rising edge
//   RST         asynchronous active-high reset
//   imemREN     datapath fetch request
//   imemaddr    datapath fetch address: index [IDX_W+1:2], tag [31:IDX_W+2]
//   ihit        requested word is valid this cycle
//   imemload    instruction word to the datapath (0 when ihit=0)
//   iREN        memory read request (high only in FETCH)
//   iaddr       memory word address (0 in IDLE)
//   iwait       memory busy; iload is valid when iwait=0 and iREN=1
//   iload       memory read data
//   flush       invalidate all lines, return to IDLE
//   hit_count   saturating hit counter (0 when statistics are disabled)
//   miss_count  saturating miss counter (0 when statistics are disabled)
//
// Build option
//   ICACHE_STATS_EN  when defined, builds the hit/miss statistics counters.
//                    Otherwise both count ports are tied to zero.
// -----------------------------------------------------------------------------
module icache #(
  parameter int NSETS = 16,
  parameter int IDX_W = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  input  logic        flush,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t             state_reg;
  logic [31:0]        miss_addr_reg;
  logic [NSETS-1:0]   valid_reg;

  // Tag and data arrays carry no reset. The valid bits alone qualify them.
  logic [TAG_W-1:0]   tag_mem  [NSETS];
  logic [31:0]        data_mem [NSETS];

  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   fill_idx;
  logic               hit;
  logic               fill_en;
  logic               miss_start;

  // The two low address bits select a byte within the word. The cache ignores them.
  logic               unused_addr_bits;
  assign unused_addr_bits = ^imemaddr[1:0];

  assign req_idx  = imemaddr[IDX_W+1:2];
  assign req_tag  = imemaddr[31:IDX_W+2];
  assign fill_idx = miss_addr_reg[IDX_W+1:2];

  assign hit = imemREN && (state_reg == IDLE) && valid_reg[req_idx]
               && (tag_mem[req_idx] == req_tag);

  // Flush takes priority over a fill that completes in the same cycle.
  assign fill_en    = (state_reg == FETCH) && !iwait && !flush;
  assign miss_start = (state_reg == IDLE) && imemREN && !hit && !flush;

  assign ihit     = hit;
  assign imemload = hit ? data_mem[req_idx] : 32'h0;

  // These outputs decode straight from the state flop. A reset therefore drops
  // iREN immediately, without waiting for a clock edge.
  assign iREN  = (state_reg == FETCH);
  assign iaddr = (state_reg == FETCH) ? miss_addr_reg : 32'h0;

  // Controller: state, latched miss address and valid bits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= IDLE;
      miss_addr_reg <= 32'h0;
      valid_reg     <= '0;
    end else if (flush) begin
      state_reg <= IDLE;
      valid_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (imemREN && !hit) begin
            state_reg     <= FETCH;
            miss_addr_reg <= {imemaddr[31:2], 2'b00};
          end
        end
        FETCH: begin
          // A change of imemaddr does not redirect a fill that has already started.
          if (!iwait) begin
            state_reg           <= IDLE;
            valid_reg[fill_idx] <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Line fill: replace tag and data unconditionally.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_mem[fill_idx]  <= miss_addr_reg[31:IDX_W+2];
      data_mem[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_reg;
  logic [31:0] miss_count_reg;

  // Saturating counters. Flush does not clear them; only reset does.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_count_reg  <= 32'h0;
      miss_count_reg <= 32'h0;
    end else begin
      if (hit && (hit_count_reg != 32'hFFFF_FFFF))
        hit_count_reg <= hit_count_reg + 32'd1;
      if (miss_start && (miss_count_reg != 32'hFFFF_FFFF))
        miss_count_reg <= miss_count_reg + 32'd1;
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;
`else
  logic unused_miss_start;
  assign unused_miss_start = miss_start;

  assign hit_count  = 32'h0;
  assign miss_count = 32'h0;
`endif

endmodule

// File: tb/tb_icache.sv
// -----------------------------------------------------------------------------
// tb_icache -- self-checking bench for icache.
// A behavioural memory answers iREN requests after a programmable number of
// wait cycles. Each issued fetch pushes the word the memory model holds for
// that address into exp_q. The entry is popped and compared when ihit rises.
// -----------------------------------------------------------------------------
module tb_icache;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'h0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks   = 0;
  int failures = 0;
  int mem_wait = 0;
  int wait_cnt = 0;
  int last_ren = 0;

  logic [31:0] exp_q [$];

  icache #(.NSETS(16), .IDX_W(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .flush      (flush),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h2001_0005;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Memory model: holds iwait high for mem_wait cycles of each request.
  always @(negedge CLK) begin
    if (iREN) begin
      if (wait_cnt < mem_wait) begin
        iwait = 1'b1;
        wait_cnt++;
      end else begin
        iwait = 1'b0;
        iload = mem_word(iaddr);
      end
    end else begin
      wait_cnt = 0;
      iwait    = 1'b1;
      iload    = 32'hDEAD_BEEF;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for ihit, checking iaddr on every request cycle. It then
  // pops the scoreboard and checks the returned data and the latency.
  task automatic wait_hit(input int exp_n, input logic [31:0] exp_addr, input string tag);
    int n;
    int ren;
    logic [31:0] exp;
    n   = 0;
    ren = 0;
    #1;
    while (!ihit && n < 50) begin
      if (iREN) begin
        ren++;
        check_val({tag, "_iaddr"}, iaddr, exp_addr);
      end
      @(negedge CLK);
      #1;
      n++;
    end
    last_ren = ren;
    if (!ihit) begin
      check_val({tag, "_timeout"}, 32'(ihit), 32'd1);
    end else if (exp_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check_val({tag, "_data"}, imemload, exp);
      check_val({tag, "_latency"}, 32'(n), 32'(exp_n));
      $display("fetch %-10s addr=%h data=%h cycles=%0d", tag, imemaddr, imemload, n);
    end
  endtask

  task automatic do_fetch(input logic [31:0] a, input int exp_n, input string tag);
    @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = a;
    exp_q.push_back(mem_word(a));
    wait_hit(exp_n, {a[31:2], 2'b00}, tag);
  endtask

  initial begin
    int phase;
    int k;
    logic [31:0] exp;

    // Reset state
    repeat (2) @(negedge CLK);
    #1;
    check_val("rst_ihit", 32'(ihit), 32'd0);
    check_val("rst_imemload", imemload, 32'h0);
    check_val("rst_iREN", 32'(iREN), 32'd0);
    check_val("rst_iaddr", iaddr, 32'h0);
    check_val("rst_hit_count", hit_count, 32'h0);
    check_val("rst_miss_count", miss_count, 32'h0);
    RST = 1'b0;

    // Cold miss with three wait cycles
    mem_wait = 3;
    do_fetch(32'h0000_0040, 5, "cold");
    check_val("cold_ren_cycles", 32'(last_ren), 32'd4);
    do_fetch(32'h0000_0040, 0, "cold_hit");

    // Conflict on index 0
    mem_wait = 1;
    do_fetch(32'h0000_0080, 3, "conf_80");
    do_fetch(32'h0000_0040, 3, "conf_40");
    do_fetch(32'h0000_0040, 0, "conf_40h");

    // Address change while FETCH is still waiting
    mem_wait = 2;
    @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0004;
    #1;
    check_val("chg_miss_ihit", 32'(ihit), 32'd0);
    check_val("chg_miss_load", imemload, 32'h0);
    @(negedge CLK);
    #1;
    check_val("chg_iREN", 32'(iREN), 32'd1);
    check_val("chg_iaddr0", iaddr, 32'h0000_0004);
    imemaddr = 32'h0000_0008;
    exp_q.push_back(mem_word(32'h0000_0008));
    phase = 0;
    for (k = 0; k < 50 && !ihit; k++) begin
      @(negedge CLK);
      #1;
      if (iREN)
        check_val((phase == 0) ? "chg_iaddr_old" : "chg_iaddr_new", iaddr,
                  (phase == 0) ? 32'h0000_0004 : 32'h0000_0008);
      else if (!ihit)
        phase = 1;
    end
    check_val("chg_gap_seen", 32'(phase), 32'd1);
    check_val("chg_ihit", 32'(ihit), 32'd1);
    if (ihit && exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      check_val("chg_data", imemload, exp);
      $display("fetch %-10s addr=%h data=%h cycles=%0d", "chg_8", imemaddr, imemload, k);
    end
    do_fetch(32'h0000_0004, 0, "chg_4_hit");

    // Flush in the same cycle as the fill
    mem_wait = 1;
    @(negedge CLK);
    imemaddr = 32'h0000_000C;
    for (k = 0; k < 20; k++) begin
      @(negedge CLK);
      #1;
      if (iREN && !iwait) break;
    end
    check_val("ff_arm", 32'(iREN & ~iwait), 32'd1);
    flush = 1'b1;
    @(negedge CLK);
    #1;
    check_val("ff_idle", 32'(iREN), 32'd0);
    check_val("ff_nofill", 32'(ihit), 32'd0);
    flush = 1'b0;
    exp_q.push_back(mem_word(32'h0000_000C));
    wait_hit(3, 32'h0000_000C, "ff_refetch");

    // Flush does not mask ihit in its own cycle
    flush = 1'b1;
    #1;
    check_val("flush_same_cycle", 32'(ihit), 32'd1);
    @(negedge CLK);
    #1;
    check_val("flush_after", 32'(ihit), 32'd0);
    flush   = 1'b0;
    imemREN = 1'b0;
    do_fetch(32'h0000_0040, 3, "post_fl_40");
    do_fetch(32'h0000_0004, 3, "post_fl_4");
    do_fetch(32'h0000_0008, 3, "post_fl_8");

    // Asynchronous reset in the middle of FETCH
    mem_wait = 5;
    @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0100;
    @(negedge CLK);
    #1;
    check_val("arst_pre_iREN", 32'(iREN), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check_val("arst_iREN", 32'(iREN), 32'd0);
    check_val("arst_iaddr", iaddr, 32'h0);
    check_val("arst_ihit", 32'(ihit), 32'd0);
    check_val("arst_imemload", imemload, 32'h0);
    imemREN = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    RST = 1'b0;
    mem_wait = 0;
    do_fetch(32'h0000_0040, 2, "arst_40");
    do_fetch(32'h0000_0100, 2, "arst_100");

    // Statistics: 2 misses and 5 hit cycles after a fresh reset
    @(negedge CLK);
    imemREN = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    #1;
    check_val("st_rst_hits", hit_count, 32'h0);
    check_val("st_rst_misses", miss_count, 32'h0);
    RST = 1'b0;
    do_fetch(32'h0000_0010, 2, "st_m10");
    do_fetch(32'h0000_0014, 2, "st_m14");
    do_fetch(32'h0000_0010, 0, "st_h10");
    do_fetch(32'h0000_0014, 0, "st_h14");
    do_fetch(32'h0000_0010, 0, "st_h10b");
    @(negedge CLK);
    imemREN = 1'b0;
    #1;
`ifdef ICACHE_STATS_EN
    check_val("st_hit_count", hit_count, 32'd5);
    check_val("st_miss_count", miss_count, 32'd2);
`else
    check_val("st_hit_count", hit_count, 32'd0);
    check_val("st_miss_count", miss_count, 32'd0);
`endif
    check_val("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
